// File: rtl/lane_collision_ctrl_if.sv
// ----------------------------------------------------------------------------
// lane_collision_ctrl_if
//   Signal bundle between the car/frog position sources and the lane
//   collision controller.
//
//   Parameter:
//     NUM_LANES     number of car lanes (sets the width of i_cars_x)
//
//   Signals:
//     i_start       start/restart request, level-sensitive
//     i_frog_x      frog column (5 bits)
//     i_frog_y      frog row (4 bits)
//     i_cars_x      packed car X positions, lane i at [5i+4:5i]
//     o_level       current level, fed back to the car movers
//     o_lives       remaining lives
//     o_hit         one-cycle pulse when a collision is taken
//     o_frog_reset  one-cycle pulse to respawn the frog
//     o_state       controller FSM state (debug/observability)
//     o_game_over   high while the game is over
//
//   Handshake: there is no valid/ready pair. Every input is sampled on every
//   rising clock edge, and every output is a plain registered level or a
//   one-cycle pulse that the consumer must take on the cycle it is high.
//
//   Modports: master drives the inputs (position sources / bench),
//   slave is the controller itself.
// ----------------------------------------------------------------------------
interface lane_collision_ctrl_if #(
    parameter int NUM_LANES = 4
) ();
    logic                     i_start;
    logic [4:0]               i_frog_x;
    logic [3:0]               i_frog_y;
    logic [5*NUM_LANES-1:0]   i_cars_x;
    logic [4:0]               o_level;
    logic [1:0]               o_lives;
    logic                     o_hit;
    logic                     o_frog_reset;
    logic [2:0]               o_state;
    logic                     o_game_over;

    modport master (
        output i_start, i_frog_x, i_frog_y, i_cars_x,
        input  o_level, o_lives, o_hit, o_frog_reset, o_state, o_game_over
    );

    modport slave (
        input  i_start, i_frog_x, i_frog_y, i_cars_x,
        output o_level, o_lives, o_hit, o_frog_reset, o_state, o_game_over
    );
endinterface

// File: rtl/lane_collision_ctrl.sv
// ----------------------------------------------------------------------------
// lane_collision_ctrl
//   Game-state controller downstream of the per-lane car movers. Compares each
//   lane's car X position against the frog position, tracks lives and level,
//   and issues hit / frog respawn pulses.
//
//   Ports:
//     i_Clk   game clock (same slow clock as the car movers)
//     i_Rst   synchronous, active-high reset
//     bus     lane_collision_ctrl_if.slave (see interface file for signals)
//
//   Parameters:
//     NUM_LANES (1..8), FIRST_LANE_ROW, GOAL_ROW, START_LIVES (1..3),
//     MAX_LEVEL (1..31), PAUSE_TICKS (1..255)
//
//   Optional build macro:
//     COLLISION_SWEEP_EN  also flag a hit when the car moved off the frog's
//                         column this tick (frog and car swapped cells).
//
//   FSM states (o_state): IDLE=0, PLAY=1, HIT=2, LEVEL_UP=3, OVER=4.
// ----------------------------------------------------------------------------
module lane_collision_ctrl #(
    parameter int NUM_LANES      = 4,
    parameter int FIRST_LANE_ROW = 1,
    parameter int GOAL_ROW       = 0,
    parameter int START_LIVES    = 3,
    parameter int MAX_LEVEL      = 31,
    parameter int PAUSE_TICKS    = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    lane_collision_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PLAY     = 3'd1,
        ST_HIT      = 3'd2,
        ST_LEVEL_UP = 3'd3,
        ST_OVER     = 3'd4
    } state_t;

    localparam logic [4:0] LEVEL_MAX  = 5'(MAX_LEVEL);
    localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
    localparam logic [7:0] PAUSE_LOAD = 8'(PAUSE_TICKS - 1);
    localparam logic [3:0] GOAL_Y     = 4'(GOAL_ROW);

    state_t       state_q, state_d;
    logic [4:0]   level_q, level_d;
    logic [1:0]   lives_q, lives_d;
    logic [7:0]   pause_q, pause_d;
    logic         hit_pulse_q, hit_pulse_d;
    logic         frog_reset_q, frog_reset_d;

    logic         hit_q, goal_q;
    logic         hit_det, goal_det;
    logic         play_reentry;

`ifdef COLLISION_SWEEP_EN
    logic [5*NUM_LANES-1:0] prev_cars_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            prev_cars_q <= '0;
        end else begin
            prev_cars_q <= bus.i_cars_x;
        end
    end
`endif

    // Per-lane compare. Lane rows are formed at 4 bits so a frog row outside
    // the lane range simply never matches any lane.
    always_comb begin
        hit_det = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (bus.i_frog_y == 4'(FIRST_LANE_ROW + i)) begin
                if (bus.i_frog_x == bus.i_cars_x[5*i +: 5]) begin
                    hit_det = 1'b1;
                end
`ifdef COLLISION_SWEEP_EN
                // Car stepped out of the frog's cell this tick: the frog and
                // car passed through each other between samples.
                if ((bus.i_frog_x == prev_cars_q[5*i +: 5]) &&
                    (bus.i_cars_x[5*i +: 5] != prev_cars_q[5*i +: 5])) begin
                    hit_det = 1'b1;
                end
`endif
            end
        end
    end

    assign goal_det = (bus.i_frog_y == GOAL_Y);

    // Next-state / output logic.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        lives_d      = lives_q;
        pause_d      = pause_q;
        hit_pulse_d  = 1'b0;
        frog_reset_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d      = ST_PLAY;
                    frog_reset_d = 1'b1;
                end
            end

            ST_PLAY: begin
                // A collision wins over a goal seen in the same cycle.
                if (hit_q) begin
                    hit_pulse_d = 1'b1;
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        pause_d = PAUSE_LOAD;
                        state_d = ST_HIT;
                    end else begin
                        lives_d = 2'd0;
                        state_d = ST_OVER;
                    end
                end else if (goal_q) begin
                    if (level_q >= LEVEL_MAX) begin
                        level_d = LEVEL_MAX;
                    end else begin
                        level_d = level_q + 5'd1;
                    end
                    pause_d = PAUSE_LOAD;
                    state_d = ST_LEVEL_UP;
                end
            end

            ST_HIT, ST_LEVEL_UP: begin
                // Loaded with PAUSE_TICKS-1 on entry, so the state is held
                // for exactly PAUSE_TICKS cycles.
                if (pause_q == 8'd0) begin
                    state_d      = ST_PLAY;
                    frog_reset_d = 1'b1;
                end else begin
                    pause_d = pause_q - 8'd1;
                end
            end

            ST_OVER: begin
                if (bus.i_start) begin
                    level_d      = 5'd1;
                    lives_d      = LIVES_INIT;
                    state_d      = ST_PLAY;
                    frog_reset_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Entering PLAY from any other state discards detections taken before
    // the respawn so a stale hit/goal is never acted on.
    assign play_reentry = (state_d == ST_PLAY) && (state_q != ST_PLAY);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= ST_IDLE;
            level_q      <= 5'd1;
            lives_q      <= LIVES_INIT;
            pause_q      <= 8'd0;
            hit_pulse_q  <= 1'b0;
            frog_reset_q <= 1'b0;
            hit_q        <= 1'b0;
            goal_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            pause_q      <= pause_d;
            hit_pulse_q  <= hit_pulse_d;
            frog_reset_q <= frog_reset_d;
            if (play_reentry) begin
                hit_q  <= 1'b0;
                goal_q <= 1'b0;
            end else begin
                hit_q  <= hit_det;
                goal_q <= goal_det;
            end
        end
    end

    assign bus.o_level      = level_q;
    assign bus.o_lives      = lives_q;
    assign bus.o_hit        = hit_pulse_q;
    assign bus.o_frog_reset = frog_reset_q;
    assign bus.o_state      = state_q;
    assign bus.o_game_over  = (state_q == ST_OVER);

endmodule

// File: tb/tb_lane_collision_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lane_collision_ctrl
//   Directed bench for lane_collision_ctrl (default parameters). Inputs are
//   driven 1 time unit after the rising edge and outputs are checked at the
//   same point, so every check sees the registers settled after an edge.
// ----------------------------------------------------------------------------
module tb_lane_collision_ctrl;

    localparam int S_IDLE = 0;
    localparam int S_PLAY = 1;
    localparam int S_HIT  = 2;
    localparam int S_LVL  = 3;
    localparam int S_OVER = 4;

`ifdef COLLISION_SWEEP_EN
    localparam int SWEEP = 1;
`else
    localparam int SWEEP = 0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   lvl_exp;
    int   lives_exp;

    lane_collision_ctrl_if #(.NUM_LANES(4)) bus ();

    lane_collision_ctrl #(
        .NUM_LANES      (4),
        .FIRST_LANE_ROW (1),
        .GOAL_ROW       (0),
        .START_LIVES    (3),
        .MAX_LEVEL      (31),
        .PAUSE_TICKS    (8)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus.slave)
    );

    // ------------------------------------------------------------ clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ helpers
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input int st, input int lvl,
                              input int lvs, input int hit, input int fr,
                              input int go);
        check({tag, ".state"},      int'(bus.o_state),      st);
        check({tag, ".level"},      int'(bus.o_level),      lvl);
        check({tag, ".lives"},      int'(bus.o_lives),      lvs);
        check({tag, ".hit"},        int'(bus.o_hit),        hit);
        check({tag, ".frog_reset"}, int'(bus.o_frog_reset), fr);
        check({tag, ".game_over"},  int'(bus.o_game_over),  go);
    endtask

    task automatic set_frog(input int x, input int y);
        bus.i_frog_x = 5'(x);
        bus.i_frog_y = 4'(y);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.i_start  = 1'b0;
        set_frog(0, 15);
        bus.i_cars_x = {5'd6, 5'd5, 5'd4, 5'd3};

        // Reset values.
        step(2);
        expect_all("reset", S_IDLE, 1, 3, 0, 0, 0);
        rst = 1'b0;
        step(1);
        expect_all("idle_hold", S_IDLE, 1, 3, 0, 0, 0);

        // Start: one edge to PLAY with a single respawn pulse.
        bus.i_start = 1'b1;
        step(1);
        expect_all("start", S_PLAY, 1, 3, 0, 1, 0);
        bus.i_start = 1'b0;
        step(1);
        expect_all("start_after", S_PLAY, 1, 3, 0, 0, 0);

        // Frog (7,2) on lane 1 car at x=7: hit shows two edges later.
        bus.i_cars_x[9:5] = 5'd7;
        set_frog(7, 2);
        step(1);
        expect_all("hit_lat1", S_PLAY, 1, 3, 0, 0, 0);
        step(1);
        expect_all("hit_take", S_HIT, 1, 2, 1, 0, 0);
        set_frog(0, 15);
        step(1);
        expect_all("hit_pause1", S_HIT, 1, 2, 0, 0, 0);
        step(6);
        expect_all("hit_pause8", S_HIT, 1, 2, 0, 0, 0);
        step(1);
        expect_all("hit_return", S_PLAY, 1, 2, 0, 1, 0);

        // Goal repeatedly: level climbs 2..31 then saturates at 31.
        set_frog(0, 0);
        lvl_exp = 1;
        for (int i = 0; i < 31; i++) begin
            lvl_exp = (lvl_exp < 31) ? lvl_exp + 1 : 31;
            step(2);
            expect_all($sformatf("lvl_up%0d", i), S_LVL, lvl_exp, 2, 0, 0, 0);
            step(7);
            check($sformatf("lvl_hold%0d", i), int'(bus.o_state), S_LVL);
            step(1);
            expect_all($sformatf("lvl_ret%0d", i), S_PLAY, lvl_exp, 2, 0, 1, 0);
        end
        set_frog(0, 15);

        // Second hit: lives 2 -> 1.
        set_frog(7, 2);
        step(2);
        expect_all("hit2_take", S_HIT, 31, 1, 1, 0, 0);
        set_frog(0, 15);
        step(8);
        expect_all("hit2_return", S_PLAY, 31, 1, 0, 1, 0);

        // Last life: lane 0 car at x=3, frog (3,1) -> OVER, level untouched.
        set_frog(3, 1);
        step(2);
        expect_all("over_take", S_OVER, 31, 0, 1, 0, 1);
        set_frog(0, 15);
        step(1);
        expect_all("over_hold1", S_OVER, 31, 0, 0, 0, 1);
        step(3);
        expect_all("over_hold4", S_OVER, 31, 0, 0, 0, 1);

        // Restart from OVER.
        bus.i_start = 1'b1;
        step(1);
        expect_all("restart", S_PLAY, 1, 3, 0, 1, 0);
        bus.i_start = 1'b0;

        // Reset during the HIT pause (count 4): straight back to IDLE.
        set_frog(7, 2);
        step(2);
        expect_all("hit3_take", S_HIT, 1, 2, 1, 0, 0);
        set_frog(0, 15);
        step(3);
        check("hit3_mid.state", int'(bus.o_state), S_HIT);
        rst = 1'b1;
        step(1);
        expect_all("rst_mid_hit", S_IDLE, 1, 3, 0, 0, 0);
        rst = 1'b0;
        step(1);
        expect_all("rst_after", S_IDLE, 1, 3, 0, 0, 0);

        bus.i_start = 1'b1;
        step(1);
        expect_all("start2", S_PLAY, 1, 3, 0, 1, 0);
        bus.i_start = 1'b0;

        // Swap case: car 10 -> 11 while the frog steps into (10,1). Only the
        // sweep build counts it.
        bus.i_cars_x[4:0] = 5'd10;
        step(1);
        bus.i_cars_x[4:0] = 5'd11;
        set_frog(10, 1);
        step(1);
        bus.i_cars_x[4:0] = 5'd3;
        set_frog(0, 15);
        step(1);
        lives_exp = 3 - SWEEP;
        expect_all("sweep", (SWEEP != 0) ? S_HIT : S_PLAY, 1, lives_exp,
                   SWEEP, 0, 0);
        step(8);
        check("sweep_settle.state", int'(bus.o_state), S_PLAY);

        // Row 5 is beyond the last lane (rows 1..4): no hit on a matching x.
        set_frog(6, 5);
        step(3);
        expect_all("row_out", S_PLAY, 1, lives_exp, 0, 0, 0);

        // Off-grid car value 25: x=24 misses, x=25 hits.
        bus.i_cars_x[14:10] = 5'd25;
        set_frog(24, 3);
        step(3);
        expect_all("car25_miss", S_PLAY, 1, lives_exp, 0, 0, 0);
        set_frog(25, 3);
        step(2);
        expect_all("car25_hit", S_HIT, 1, lives_exp - 1, 1, 0, 0);
        set_frog(0, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
